// File: rtl/key_event_arbiter.sv
// Key edge detector and round-robin arbiter feeding a small event FIFO.
// Press/release edges of 25 debounced keys become queued key events.
module key_event_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] btn_ok,
    output logic [4:0]  evt_code,
    output logic        evt_rel,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [4:0]  evt_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state, state_n;
    logic [24:0] prev;
    logic [24:0] press_pend, rel_pend;
    logic [24:0] press_pend_n, rel_pend_n;
    logic [24:0] press_edge, rel_edge;
    logic [24:0] press_clr, rel_clr;
    logic [24:0] pend;
    logic [4:0]  rr_ptr, rr_next;
    logic [4:0]  g_idx;
    logic        g_rel, found, grant;
    logic [5:0]  sum;
    logic        pop, can_push, ovf_set;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [4:0]    count_n;
    logic [5:0]    head_n;

    assign evt_valid = (evt_count != 5'd0);

    always_comb begin
        state_n = RUN;
        press_edge = '0;
        rel_edge = '0;
        if (state == RUN) begin
            press_edge = btn_ok & ~prev;
            rel_edge = ~btn_ok & prev;
        end
    end

    // Round-robin search starting at rr_ptr, wrapping 24 -> 0
    always_comb begin
        pend = press_pend | rel_pend;
        found = 1'b0;
        g_idx = 5'd0;
        sum = 6'd0;
        for (int i = 0; i < 25; i++) begin
            sum = {1'b0, rr_ptr} + 6'(i);
            if (sum >= 6'd25) sum = sum - 6'd25;
            if (!found && pend[sum[4:0]]) begin
                found = 1'b1;
                g_idx = sum[4:0];
            end
        end
        g_rel = ~press_pend[g_idx];
    end

    always_comb begin
        pop = evt_valid & evt_ready;
        can_push = (evt_count < 5'(DEPTH)) || pop;
        grant = found & can_push;
        press_clr = '0;
        rel_clr = '0;
        rr_next = rr_ptr;
        if (grant) begin
            if (g_rel) rel_clr[g_idx] = 1'b1;
            else press_clr[g_idx] = 1'b1;
            // Stay on the key while its release is still queued behind the press
            if (!(!g_rel && rel_pend[g_idx]))
                rr_next = (g_idx == 5'd24) ? 5'd0 : g_idx + 5'd1;
        end
        press_pend_n = (press_pend & ~press_clr) | press_edge;
        rel_pend_n = (rel_pend & ~rel_clr) | rel_edge;
        ovf_set = |(press_edge & press_pend & ~press_clr)
                | |(rel_edge & rel_pend & ~rel_clr);
    end

    always_comb begin
        count_n = evt_count + {4'd0, grant} - {4'd0, pop};
        rd_n = pop ? rd_ptr + AW'(1) : rd_ptr;
        if (grant && wr_ptr == rd_n) head_n = {g_rel, g_idx};
        else head_n = mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (grant) mem[wr_ptr] <= {g_rel, g_idx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            prev <= '0;
            press_pend <= '0;
            rel_pend <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            evt_count <= '0;
            evt_code <= '0;
            evt_rel <= 1'b0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            prev <= btn_ok;
            press_pend <= press_pend_n;
            rel_pend <= rel_pend_n;
            rr_ptr <= rr_next;
            if (grant) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_n;
            evt_count <= count_n;
            if (count_n != 5'd0) begin
                evt_code <= head_n[4:0];
                evt_rel <= head_n[5];
            end
            if (ovf_set) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with hand-computed expectations.
module tb_key_event_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] btn_ok;
    logic [4:0]  evt_code;
    logic        evt_rel;
    logic        evt_valid;
    logic        evt_ready;
    logic        ovf;
    logic        ovf_clr;
    logic [4:0]  evt_count;

    int checks = 0;
    int errors = 0;

    key_event_arbiter #(.DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .btn_ok(btn_ok),
        .evt_code(evt_code),
        .evt_rel(evt_rel),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [4:0] code,
                           input logic rel);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_code"}, 32'(evt_code), 32'(code));
        chk({tag, "_rel"}, 32'(evt_rel), 32'(rel));
    endtask

    initial begin
        rst = 1'b1;
        btn_ok = 25'd0;
        btn_ok[3] = 1'b1;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        tick(3);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Key 3 held through reset: no press, release reported
        rst = 1'b0;
        tick(4);
        chk("held_no_evt", 32'(evt_valid), 32'd0);
        btn_ok[3] = 1'b0;
        tick(1);
        chk("lat_n1", 32'(evt_valid), 32'd0);
        tick(1);
        chk_evt("rel3", 5'd3, 1'b1);
        evt_ready = 1'b1;
        tick(1);
        chk("rel3_pop", 32'(evt_count), 32'd0);

        // Multiple keys in one cycle, round-robin from 0, then wrap
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        btn_ok[2] = 1'b1;
        btn_ok[7] = 1'b1;
        btn_ok[24] = 1'b1;
        tick(2);
        chk_evt("rr2", 5'd2, 1'b0);
        tick(1);
        chk_evt("rr7", 5'd7, 1'b0);
        tick(1);
        chk_evt("rr24", 5'd24, 1'b0);
        chk("rr24_cnt", 32'(evt_count), 32'd1);
        tick(1);
        chk("rr_empty", 32'(evt_valid), 32'd0);
        btn_ok[0] = 1'b1;
        tick(2);
        chk_evt("wrap0", 5'd0, 1'b0);
        tick(1);
        chk("wrap_pop", 32'(evt_count), 32'd0);

        // Press and release on consecutive cycles keep their order
        evt_ready = 1'b0;
        btn_ok[5] = 1'b1;
        tick(1);
        btn_ok[5] = 1'b0;
        tick(2);
        chk("k5_cnt", 32'(evt_count), 32'd2);
        chk_evt("k5_press", 5'd5, 1'b0);
        tick(2);
        chk_evt("k5_hold", 5'd5, 1'b0);
        evt_ready = 1'b1;
        tick(1);
        chk_evt("k5_rel", 5'd5, 1'b1);
        tick(1);
        chk("k5_empty", 32'(evt_count), 32'd0);

        // Nine presses fill the FIFO; ninth stays pending
        evt_ready = 1'b0;
        for (int k = 10; k <= 18; k++) btn_ok[k] = 1'b1;
        tick(9);
        chk("full_cnt", 32'(evt_count), 32'd8);
        tick(3);
        chk("full_hold", 32'(evt_count), 32'd8);
        chk("full_ovf0", 32'(ovf), 32'd0);
        chk_evt("full_head", 5'd10, 1'b0);
        btn_ok[18] = 1'b0;
        tick(1);
        chk("rel18_ovf0", 32'(ovf), 32'd0);
        btn_ok[18] = 1'b1;
        tick(1);
        chk("repress_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO: simultaneous push and pop
        evt_ready = 1'b1;
        tick(1);
        chk("pp_cnt1", 32'(evt_count), 32'd8);
        chk_evt("pp_head1", 5'd11, 1'b0);
        tick(1);
        chk("pp_cnt2", 32'(evt_count), 32'd8);
        chk_evt("pp_head2", 5'd12, 1'b0);
        tick(4);
        evt_ready = 1'b0;
        chk("drain4", 32'(evt_count), 32'd4);
        chk_evt("drain_head", 5'd16, 1'b0);

        // Asynchronous reset mid-operation with pending events
        btn_ok[20] = 1'b1;
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_count", 32'(evt_count), 32'd0);
        chk("arst_code", 32'(evt_code), 32'd0);
        chk("arst_rel", 32'(evt_rel), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("post_rst_valid", 32'(evt_valid), 32'd0);
        chk("post_rst_cnt", 32'(evt_count), 32'd0);
        btn_ok[0] = 1'b0;
        tick(2);
        chk_evt("post_rst_rel0", 5'd0, 1'b1);
        chk("post_rst_cnt1", 32'(evt_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set event FIFO depth (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn_ok  input  25  debounced key levels from the 5x5 scan/debounce path; bit i = key i, 1 = pressed.
REQ-005 evt_code  output  5  key index 0..24 of FIFO head event.
REQ-006 evt_rel  output  1  head event type: 0 = press, 1 = release.
REQ-007 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-008 evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-009 ovf  output  1  sticky lost-event flag.
REQ-010 ovf_clr  input  1  synchronous clear of ovf.
REQ-011 evt_count  output  5  current FIFO occupancy 0..DEPTH.

Function
REQ-012 States SHALL be INIT and RUN; INIT SHALL last exactly one cycle after reset release, load prev <= btn_ok, generate no edges, then go to RUN; RUN SHALL persist until rst.
REQ-013 In RUN, press edge = btn_ok & ~prev, release edge = ~btn_ok & prev; prev <= btn_ok every RUN cycle.
REQ-014 Each edge SHALL set its bit in a 25-bit press-pending or release-pending register at the end of the cycle it is detected.
REQ-015 Arbiter SHALL grant at most one pending event per cycle, round-robin over key index starting at rr_ptr, wrapping 24 -> 0.
REQ-016 For one key with both bits pending, press SHALL be granted first; rr_ptr SHALL remain on that key so release is granted next.
REQ-017 After granting the last pending bit of key k, rr_ptr SHALL become (k+1) mod 25; with no grant, rr_ptr SHALL hold.
REQ-018 Grant SHALL occur only if a push is permitted: evt_count<DEPTH, or evt_count==DEPTH and a pop occurs in the same cycle.
REQ-019 Granted event SHALL be written to FIFO tail and its pending bit cleared at the same clock edge.
REQ-020 A new edge on a bit cleared by a grant in the same cycle SHALL leave the bit set (set wins).
REQ-021 An edge arriving on an already-set pending bit not being granted SHALL be dropped and SHALL set ovf.
REQ-022 Pop SHALL occur when evt_valid & evt_ready; push and pop in the same cycle SHALL leave evt_count unchanged.
REQ-023 evt_code/evt_rel SHALL be registered FIFO head outputs, stable while evt_valid=1 and evt_ready=0.
REQ-024 Latency: btn_ok edge in cycle N with empty FIFO and no contention SHALL yield evt_valid=1 in cycle N+2.
REQ-025 ovf_clr SHALL clear ovf; a simultaneous new overflow SHALL win (ovf stays 1).
REQ-026 Pointer arithmetic SHALL wrap modulo DEPTH; evt_count SHALL never exceed DEPTH or underflow 0.

Reset
REQ-027 rst=1 SHALL asynchronously force state=INIT, prev=0, both pending registers=0, rr_ptr=0, FIFO empty, evt_count=0, evt_valid=0, evt_code=0, evt_rel=0, ovf=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and pending events; keys held through reset SHALL produce no press event after release.

Verification
REQ-029 Reset with btn_ok[3]=1 held, release rst -> no event; then btn_ok[3] 1->0 -> evt_code=3, evt_rel=1 two cycles later.
REQ-030 evt_ready=1, btn_ok 0 -> bits 2,7,24 set in one cycle -> events 2,7,24 (press) on consecutive cycles; then bit 0 set -> event 0 (wrap-around from rr_ptr=0 after 24).
REQ-031 Key 5 pressed and released on consecutive cycles, evt_ready=0 -> FIFO holds press 5 then release 5, in that order.
REQ-032 evt_ready=0, 9 distinct key presses -> evt_count=8, 9th stays pending, ovf=0; pressing/releasing the pending key again -> ovf=1; ovf_clr -> ovf=0.
REQ-033 FIFO full with evt_ready=1 and a pending event -> push and pop in same cycle, evt_count stays 8, head advances.
REQ-034 Assert rst while evt_count=4 and pending bits set -> all outputs at reset values immediately, no stale events after release.
